// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex/BCD counter display.
// Segment encodings are active-low, bit6=g .. bit0=a.
`timescale 1ps/1ps
package hex_disp_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_ZERO = 7'h40;

  // Indexed by digit value; concatenation runs from F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to active-low seven-segment pattern.
`timescale 1ps/1ps
module seg7_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] digit,
  output seg_t       seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/hex_counter_display.sv
// Multi-digit hex/BCD up/down counter with prescaler, snapshot register
// and registered seven-segment outputs.
`timescale 1ps/1ps
module hex_counter_display
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 5
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   en,
  input  logic                   up,
  input  logic                   bcd_mode,
  input  logic                   clear,
  input  logic                   snap,
  input  logic                   disp_sel,
  output seg_t [NUM_DIGITS-1:0]  hex,
  output logic                   tick,
  output logic                   wrap
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]          presc;
  logic [CW-1:0]          count;
  logic [CW-1:0]          snapshot;
  logic [CW-1:0]          count_next;
  logic [CW-1:0]          disp_src;
  logic [3:0]             dig;
  logic                   carry;
  logic                   step;
  seg_t [NUM_DIGITS-1:0]  seg_dec;

  assign step = en && (presc == PRE_MAX);

  // Ripple carry/borrow; carry ends up as the whole-count wrap indication.
  always_comb begin
    count_next = count;
    carry      = 1'b1;
    dig        = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = count[4*i +: 4];
      if (carry) begin
        if (up) begin
          if ((bcd_mode && dig >= 4'd9) || (!bcd_mode && dig == 4'hF)) begin
            count_next[4*i +: 4] = 4'h0;
            carry                = 1'b1;
          end else begin
            count_next[4*i +: 4] = dig + 4'h1;
            carry                = 1'b0;
          end
        end else begin
          if (dig == 4'h0) begin
            count_next[4*i +: 4] = bcd_mode ? 4'h9 : 4'hF;
            carry                = 1'b1;
          end else if (bcd_mode && dig > 4'd9) begin
            count_next[4*i +: 4] = 4'h9;
            carry                = 1'b0;
          end else begin
            count_next[4*i +: 4] = dig - 4'h1;
            carry                = 1'b0;
          end
        end
      end
    end
  end

  assign disp_src = disp_sel ? snapshot : count;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .digit (disp_src[4*g +: 4]),
      .seg   (seg_dec[g])
    );
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      presc    <= '0;
      count    <= '0;
      snapshot <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      hex      <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (snap) snapshot <= count;
      if (clear) begin
        count <= '0;
        presc <= '0;
      end else if (en) begin
        if (step) begin
          presc <= '0;
          count <= count_next;
          tick  <= 1'b1;
          wrap  <= carry;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      hex <= seg_dec;
    end
  end

endmodule

// File: tb/tb_hex_counter_display.sv
// Directed self-checking bench for hex_counter_display (6 digits, divide-by-5).
`timescale 1ps/1ps
module tb_hex_counter_display;

  logic            clock = 1'b0;
  logic            resetN, en, up, bcd_mode, clear, snap, disp_sel;
  logic [5:0][6:0] hex;
  logic            tick, wrap;
  int              n_checks = 0;
  int              n_fail   = 0;
  int              tick_cnt;

  always #5 clock = ~clock;

  hex_counter_display #(.NUM_DIGITS(6), .TICK_DIV(5)) dut (
    .clock    (clock),
    .resetN   (resetN),
    .en       (en),
    .up       (up),
    .bcd_mode (bcd_mode),
    .clear    (clear),
    .snap     (snap),
    .disp_sel (disp_sel),
    .hex      (hex),
    .tick     (tick),
    .wrap     (wrap)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [41:0] exp_hex(input logic [23:0] v);
    logic [41:0] r;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = seg_ref(v[4*i +: 4]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Enable for one full prescaler period; tick (and wrap) only on the fifth cycle.
  task automatic do_step(input string tag, input logic exp_wrap);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check({tag, " tick"}, tick, (i == 4));
      check({tag, " wrap"}, wrap, (i == 4) && exp_wrap);
    end
    en = 1'b0;
    @(negedge clock);
    check({tag, " tick end"}, tick, 1'b0);
    check({tag, " wrap end"}, wrap, 1'b0);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("after clear", hex, exp_hex(24'h000000));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; en = 1'b0; up = 1'b1; bcd_mode = 1'b1;
    clear = 1'b0; snap = 1'b0; disp_sel = 1'b0;

    #1000;
    check("reset hex", hex, exp_hex(24'h000000));
    check("reset tick", tick, 1'b0);
    check("reset wrap", wrap, 1'b0);
    #4000;
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle tick", tick, 1'b0);
      check("idle wrap", wrap, 1'b0);
    end
    check("idle hex", hex, exp_hex(24'h000000));

    // 50 enabled cycles in BCD up mode: ten steps
    en = 1'b1; tick_cnt = 0;
    repeat (50) begin
      @(negedge clock);
      if (tick) tick_cnt++;
    end
    en = 1'b0;
    check("bcd up tick count", tick_cnt, 10);
    @(negedge clock);
    check("bcd up 10", hex, exp_hex(24'h000010));

    // Down wraps from zero, BCD then hex
    clear_pulse();
    up = 1'b0;
    do_step("bcd down wrap", 1'b1);
    check("bcd 999999", hex, exp_hex(24'h999999));
    clear_pulse();
    bcd_mode = 1'b0;
    do_step("hex down wrap", 1'b1);
    check("hex FFFFFF", hex, exp_hex(24'hFFFFFF));

    // BCD with non-decimal digits left over from hex mode
    bcd_mode = 1'b1;
    do_step("bcd down from F", 1'b0);
    check("FFFFF9", hex, exp_hex(24'hFFFFF9));
    up = 1'b1;
    do_step("bcd up over F", 1'b1);
    check("up wrap zero", hex, exp_hex(24'h000000));

    // Snapshot and display select
    for (int i = 0; i < 3; i++) do_step("count to 3", 1'b0);
    snap = 1'b1;
    @(negedge clock);
    snap = 1'b0;
    for (int i = 0; i < 4; i++) do_step("count to 7", 1'b0);
    check("live 7", hex, exp_hex(24'h000007));
    disp_sel = 1'b1;
    @(negedge clock);
    check("snapshot 3", hex, exp_hex(24'h000003));
    disp_sel = 1'b0;
    @(negedge clock);
    check("back to live 7", hex, exp_hex(24'h000007));

    snap = 1'b1; clear = 1'b1;
    @(negedge clock);
    snap = 1'b0; clear = 1'b0;
    disp_sel = 1'b1;
    @(negedge clock);
    check("snap pre-clear 7", hex, exp_hex(24'h000007));
    disp_sel = 1'b0;
    @(negedge clock);
    check("live cleared", hex, exp_hex(24'h000000));

    // Clear coincident with a step
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("pre clear tick", tick, 1'b0);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear step tick", tick, 1'b0);
    check("clear step wrap", wrap, 1'b0);
    do_step("after clear step", 1'b0);
    check("count 1 after clear", hex, exp_hex(24'h000001));

    // Reset mid-count at 42, prescaler 3
    clear_pulse();
    en = 1'b1; tick_cnt = 0;
    repeat (213) begin
      @(negedge clock);
      if (tick) tick_cnt++;
    end
    check("tick count 42", tick_cnt, 42);
    check("count 42", hex, exp_hex(24'h000042));
    #2;
    resetN = 1'b0;
    #1;
    check("async reset hex", hex, exp_hex(24'h000000));
    check("async reset tick", tick, 1'b0);
    check("async reset wrap", wrap, 1'b0);
    @(negedge clock);
    check("held reset hex", hex, exp_hex(24'h000000));
    resetN = 1'b1;
    do_step("post reset", 1'b0);
    check("post reset count 1", hex, exp_hex(24'h000001));
    disp_sel = 1'b1;
    @(negedge clock);
    check("snapshot reset", hex, exp_hex(24'h000000));
    disp_sel = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_counter_display.md
HEX_COUNTER_DISPLAY -- requirements
Module: hex_counter_display

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of 4-bit digits counted and displayed; range 1..8.
REQ-002 Parameter TICK_DIV, default 5: clock cycles per count step; range 2..2^16.
REQ-003 clock  input  1  single system clock, all state on rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  1 = prescaler and counter advance; 0 = both hold.
REQ-006 up  input  1  1 = count up, 0 = count down.
REQ-007 bcd_mode  input  1  1 = decimal digits 0-9, 0 = hex digits 0-F.
REQ-008 clear  input  1  synchronous zeroing of count and prescaler.
REQ-009 snap  input  1  capture current count into snapshot register.
REQ-010 disp_sel  input  1  0 = display live count, 1 = display snapshot.
REQ-011 hex  output  [NUM_DIGITS][7]  active-low segments per digit, bit6=g .. bit0=a; hex[0] least significant.
REQ-012 tick  output  1  one-cycle pulse on each count step.
REQ-013 wrap  output  1  one-cycle pulse when a step wraps the whole count.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 while en=1; a step occurs in the cycle prescaler==TICK_DIV-1, prescaler returns to 0.
REQ-015 tick is registered: asserted the cycle after a step occurs, for exactly one cycle.
REQ-016 Hex mode: each digit 0..F, ripple carry/borrow across all NUM_DIGITS digits.
REQ-017 BCD mode: up-step of digit 9 gives 0 plus carry; down-step of 0 gives 9 plus borrow.
REQ-018 BCD mode with a digit >9 (left from hex mode): up-step treats it as 9 (gives 0, carry); down-step gives 9.
REQ-019 Up from all-max (all 9s BCD / all Fs hex) gives all zero; down from zero gives all-max; either case pulses wrap together with tick.
REQ-020 clear has priority over a step in the same cycle: count=0, prescaler=0, no tick, no wrap.
REQ-021 snap latches the count value present before that cycle's update; snap with clear latches the pre-clear value.
REQ-022 disp_sel chooses the source for every digit; switching takes effect on hex one cycle later.
REQ-023 hex is registered: one cycle latency from count/snapshot change to segment output.
REQ-024 Segment patterns (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-025 en=0 freezes prescaler and count; clear, snap and disp_sel still act.
REQ-026 up and bcd_mode changes are sampled only at a step; no effect between steps.

Reset
REQ-027 resetN low asynchronously forces count=0, snapshot=0, prescaler=0, tick=0, wrap=0, every hex digit=7'h40.
REQ-028 Reset asserted mid-step discards the step; first step after release occurs TICK_DIV cycles after the first enabled edge.

Structure
REQ-029 Shared package hex_disp_pkg holds typedef seg_t (logic [6:0]), the 16-entry segment table constant, and SEG_ZERO (7'h40).
REQ-030 One sub-module seg7_decode (4-bit digit in, seg_t out, combinational) is instantiated once per digit.
REQ-031 Counter, prescaler, snapshot and output registers live in hex_counter_display; no other sub-modules.

Verification (NUM_DIGITS=6, TICK_DIV=5, 10 ps clock period)
REQ-032 Reset held 5 ns then released, en=0 -> all hex = 7'h40, tick=wrap=0 throughout.
REQ-033 en=1, up=1, bcd_mode=1 for 50 cycles -> count 000010, hex[1]=7'h79, hex[0]=7'h40, ten tick pulses.
REQ-034 From zero, en=1, up=0, bcd_mode=1, one step -> count 999999, all hex=7'h10, wrap high exactly one cycle; repeat with bcd_mode=0 -> FFFFFF, all hex=7'h0E.
REQ-035 Count to 3, pulse snap, run to 7, disp_sel=1 -> hex[0]=7'h30 one cycle after select; disp_sel=0 -> hex[0]=7'h78.
REQ-036 clear asserted in the same cycle as a step -> count 0, no tick, no wrap; next step after 5 further enabled cycles.
REQ-037 resetN pulsed low mid-count (count 000042, prescaler 3) -> all outputs at reset values immediately, no tick on release.
